prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): PC_W, 10, program counter width; IW, 9, instruction width; CNT_W, 16, cycle counter width.
REQ-002 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- Clk  in  1  single clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin program execution at PC 0.
- Prog_end  in  PC_W  first PC value not executed; a fetch at this PC ends the program.
- Ifetch_req  out  1  instruction fetch request.
- Ifetch_ack  in  1  instruction fetch complete; Instr is valid.
- Instr  in  IW  fetched instruction.
- Instr_reg  out  IW  latched instruction, driven to the control decoder.
- Instr_addr  out  PC_W  current PC.
- Branch, Jump, MemRead, MemWrite, RegWrite  in  1 each  decoder outputs for Instr_reg.
- Zero  in  1  ALU equality flag.
- Jump_target  in  PC_W  register-file read data used by JAL.
- Mem_req  out  1  data-memory access request.
- Mem_we  out  1  write qualifier; valid while Mem_req is high.
- Mem_ack  in  1  data-memory access complete.
- RegWrite_en  out  1  register-file write strobe.
- Busy  out  1  a program is executing.
- Done  out  1  program finished.
- Cycle_cnt  out  CNT_W  cycles spent in the current or last run.

Function
REQ-003 The block SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and DONE.
REQ-004 IDLE: on Start=1, the block SHALL load PC=0, clear Cycle_cnt and go to FETCH; otherwise it SHALL stay in IDLE.
REQ-005 FETCH: if PC==Prog_end, the block SHALL go to DONE without asserting Ifetch_req; otherwise it SHALL hold Ifetch_req=1 until it samples Ifetch_ack=1, then latch Instr into Instr_reg and go to DECODE.
REQ-006 Ifetch_ack SHALL be ignored in every state except FETCH, and Mem_ack SHALL be ignored in every state except MEM.
REQ-007 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-008 EXEC SHALL last one cycle and go to MEM if MemRead|MemWrite, else to WB if RegWrite, else to FETCH.
REQ-009 MEM: the block SHALL hold Mem_req=1 with Mem_we=MemWrite until Mem_ack=1, then go to WB if RegWrite&~MemWrite, else to FETCH.
REQ-010 WB: the block SHALL assert RegWrite_en for exactly this one cycle and then go to FETCH; RegWrite_en SHALL be 0 in all other states.
REQ-011 PC SHALL update only on a transition into FETCH from EXEC, MEM or WB, as follows:
- Jump=1: PC = Jump_target.
- else Branch&Zero: PC = PC+2.
- else: PC = PC+1.
- All PC arithmetic SHALL be modulo 2^PC_W; 1023+1 wraps to 0 and 1023+2 wraps to 1.
REQ-012 If Jump and Branch are both 1, Jump SHALL take priority.
REQ-013 Jump, Branch and Zero SHALL be sampled in the cycle that leaves EXEC, and that PC decision SHALL be held until the PC update.
REQ-014 DONE: the block SHALL hold Done=1 and Busy=0; Start=1 SHALL restart the block exactly as from IDLE.
REQ-015 Busy SHALL be 1 in FETCH, DECODE, EXEC, MEM and WB, and 0 in IDLE and DONE.
REQ-016 Start SHALL be ignored while Busy=1.
REQ-017 Cycle_cnt SHALL increment by 1 every cycle Busy=1, SHALL saturate at 2^CNT_W-1 and SHALL hold its value in DONE.
REQ-018 Minimum latency per instruction, with acks returned in the cycle the request is raised:
- ALU/register-write instruction: 4 cycles.
- EQ or other no-write instruction: 3 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
REQ-019 Instr_addr SHALL equal PC in every state.

Reset
REQ-020 Reset_n=0 SHALL immediately force the state to IDLE and set PC=0, Instr_reg=0, Cycle_cnt=0, and Ifetch_req=Mem_req=Mem_we=RegWrite_en=Busy=Done=0.
REQ-021 A reset asserted mid-fetch or mid-memory-access SHALL abandon the transaction, and a late ack SHALL have no effect.
REQ-022 After Reset_n rises, the block SHALL remain in IDLE until Start=1.

Verification
REQ-023 Prog_end=0, Start pulse -> one FETCH cycle with no Ifetch_req, then Done=1 and Cycle_cnt=1.
REQ-024 Three ADD instructions, Prog_end=3, immediate acks -> RegWrite_en pulses at cycles 4, 8 and 12 after Start; Done=1 with Cycle_cnt=13.
REQ-025 Load at PC 5 with Mem_ack delayed 3 cycles -> Mem_req high for 4 cycles, Mem_we=0, one RegWrite_en pulse, next fetch at PC 6.
REQ-026 EQ at PC 10 with Zero=1 -> next fetch at PC 12; with Zero=0 -> next fetch at PC 11; RegWrite_en never asserted.
REQ-027 JAL with Jump_target=1023 and Branch forced to 1, then ADD at 1023 -> next fetch at PC 1023, then PC wraps to 0.
REQ-028 Reset_n pulsed low while in MEM with Mem_req high -> all outputs 0 at once, state IDLE, and a later Mem_ack causes no change.

Source files
------------

// File: rtl/prog_sequencer.sv
// Multi-cycle instruction sequencer: fetches instructions through a request/ack
// handshake, steps through decode/execute/memory/write-back, tracks the program
// counter and counts cycles spent on the current run.
module prog_sequencer #(
    parameter int PC_W  = 10,
    parameter int IW    = 9,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  Prog_end,
    output logic             Ifetch_req,
    input  logic             Ifetch_ack,
    input  logic [IW-1:0]    Instr,
    output logic [IW-1:0]    Instr_reg,
    output logic [PC_W-1:0]  Instr_addr,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             Zero,
    input  logic [PC_W-1:0]  Jump_target,
    output logic             Mem_req,
    output logic             Mem_we,
    input  logic             Mem_ack,
    output logic             RegWrite_en,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_target;
    logic [PC_W-1:0]   exec_target;
    logic [IW-1:0]     instr_q;
    logic [CNT_W-1:0]  cnt;
    logic              at_end;
    logic              launch;
    logic              busy;

    assign at_end = (pc == Prog_end);
    assign launch = ((state == S_IDLE) || (state == S_DONE)) && Start;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (Start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (at_end)          state_next = S_DONE;
                else if (Ifetch_ack) state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (MemRead || MemWrite) state_next = S_MEM;
                else if (RegWrite)       state_next = S_WB;
                else                     state_next = S_FETCH;
            end
            S_MEM: begin
                if (Mem_ack) begin
                    state_next = (RegWrite && !MemWrite) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)   || (state == S_WB);
        Busy        = busy;
        Done        = (state == S_DONE);
        Ifetch_req  = (state == S_FETCH) && !at_end;
        Mem_req     = (state == S_MEM);
        Mem_we      = (state == S_MEM) && MemWrite;
        RegWrite_en = (state == S_WB);
    end

    // Next-PC decision formed from the flags present while leaving EXEC
    always_comb begin
        if (Jump)               exec_target = Jump_target;
        else if (Branch && Zero) exec_target = pc + PC_W'(2);
        else                    exec_target = pc + PC_W'(1);
    end

    // PC and the held next-PC decision; the decision is captured in EXEC so a
    // later MEM/WB detour commits it unchanged when returning to FETCH
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc        <= '0;
            pc_target <= '0;
        end else begin
            if (state == S_EXEC) pc_target <= exec_target;
            if (launch) begin
                pc <= '0;
            end else if (state_next == S_FETCH) begin
                if (state == S_EXEC)                        pc <= exec_target;
                else if ((state == S_MEM) || (state == S_WB)) pc <= pc_target;
            end
        end
    end

    // Instruction latch on a completed fetch
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_q <= '0;
        end else if ((state == S_FETCH) && !at_end && Ifetch_ack) begin
            instr_q <= Instr;
        end
    end

    // Saturating run-length counter, cleared on launch, frozen while idle/done
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (launch) begin
            cnt <= '0;
        end else if (busy && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign Instr_reg  = instr_q;
    assign Instr_addr = pc;
    assign Cycle_cnt  = cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: the bench plays instruction memory,
// decoder and data memory, checks directed vectors and randomized programs
// against a run-level reference model.
module tb_prog_sequencer;

    localparam int PC_W    = 10;
    localparam int IW      = 9;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int MEM_N   = 1 << PC_W;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ST  = 3'd2;
    localparam logic [2:0] OP_EQ  = 3'd3;
    localparam logic [2:0] OP_JAL = 3'd4;
    localparam logic [2:0] OP_NOP = 3'd5;
    localparam logic [2:0] OP_JB  = 3'd6;

    logic             Clk;
    logic             Reset_n;
    logic             Start;
    logic [PC_W-1:0]  Prog_end;
    logic             Ifetch_req;
    logic             Ifetch_ack;
    logic [IW-1:0]    Instr;
    logic [IW-1:0]    Instr_reg;
    logic [PC_W-1:0]  Instr_addr;
    logic             Branch, Jump, MemRead, MemWrite, RegWrite;
    logic             Zero;
    logic [PC_W-1:0]  Jump_target;
    logic             Mem_req;
    logic             Mem_we;
    logic             Mem_ack;
    logic             RegWrite_en;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Cycle_cnt;

    prog_sequencer #(.PC_W(PC_W), .IW(IW), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Prog_end(Prog_end),
        .Ifetch_req(Ifetch_req), .Ifetch_ack(Ifetch_ack), .Instr(Instr),
        .Instr_reg(Instr_reg), .Instr_addr(Instr_addr),
        .Branch(Branch), .Jump(Jump), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .Zero(Zero), .Jump_target(Jump_target),
        .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_ack(Mem_ack),
        .RegWrite_en(RegWrite_en), .Busy(Busy), .Done(Done), .Cycle_cnt(Cycle_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Program image: instruction, ALU zero flag, jump target and ack latencies per PC
    logic [IW-1:0]   imem    [MEM_N];
    logic            zero_mem[MEM_N];
    logic [PC_W-1:0] jt_mem  [MEM_N];
    int              flat    [MEM_N];
    int              mlat    [MEM_N];

    always_comb begin
        Instr       = imem[Instr_addr];
        Zero        = zero_mem[Instr_addr];
        Jump_target = jt_mem[Instr_addr];
    end

    // Bench-side control decoder
    always_comb begin
        Branch = 1'b0; Jump = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        case (Instr_reg[2:0])
            OP_ADD: RegWrite = 1'b1;
            OP_LD:  begin MemRead = 1'b1; RegWrite = 1'b1; end
            OP_ST:  MemWrite = 1'b1;
            OP_EQ:  Branch = 1'b1;
            OP_JAL: begin Jump = 1'b1; RegWrite = 1'b1; end
            OP_JB:  begin Jump = 1'b1; Branch = 1'b1; RegWrite = 1'b1; end
            default: ;
        endcase
    end

    // Ack responders: ack after the per-PC number of extra wait cycles
    bit resp_en = 1'b1;
    int fcnt = 0;
    int mcnt = 0;
    always @(posedge Clk) begin
        #2;
        if (resp_en) begin
            if (Ifetch_req) begin Ifetch_ack = (fcnt >= flat[Instr_addr]); fcnt++; end
            else            begin Ifetch_ack = 1'b0; fcnt = 0; end
            if (Mem_req)    begin Mem_ack = (mcnt >= mlat[Instr_addr]); mcnt++; end
            else            begin Mem_ack = 1'b0; mcnt = 0; end
        end
    end

    // Observation counters sampled on the falling edge
    int              cyc, rw_cnt, memreq_cyc, memwe_cyc, busy_cyc;
    int              rw_at[$];
    logic [PC_W-1:0] fetched[$];
    always @(negedge Clk) begin
        cyc++;
        if (Busy) busy_cyc++;
        if (RegWrite_en) begin rw_cnt++; rw_at.push_back(cyc); end
        if (Mem_req) memreq_cyc++;
        if (Mem_req && Mem_we) memwe_cyc++;
        if (Ifetch_req && Ifetch_ack) fetched.push_back(Instr_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; rw_cnt = 0; memreq_cyc = 0; memwe_cyc = 0; busy_cyc = 0;
        rw_at.delete(); fetched.delete();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < MEM_N; i++) begin
            imem[i] = {6'b101010, OP_NOP}; zero_mem[i] = 1'b0; jt_mem[i] = '0;
            flat[i] = 0; mlat[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk); #1 Reset_n = 1'b0;
        @(negedge Clk); #1 Reset_n = 1'b1;
        fcnt = 0; mcnt = 0;
    endtask

    task automatic do_start();
        @(negedge Clk); #1;
        clear_mon();
        Start = 1'b1;
        @(negedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (!Done && i < budget) begin @(negedge Clk); #1; i++; end
        check({name, "_done"}, int'(Done), 1);
    endtask

    // Reference model: walks the program with the architectural rules and
    // predicts the fetch sequence and aggregate cycle/strobe counts of one run
    logic [PC_W-1:0] exp_fetch[$];
    int e_total, e_rw, e_mem, e_we;

    task automatic model_run();
        int pc, guard;
        logic [2:0] op;
        bit is_mem, wr, jmp;
        exp_fetch.delete();
        pc = 0; guard = 0; e_total = 0; e_rw = 0; e_mem = 0; e_we = 0;
        while (pc != int'(Prog_end) && guard < 200) begin
            exp_fetch.push_back(PC_W'(pc));
            op     = imem[pc][2:0];
            is_mem = (op == OP_LD) || (op == OP_ST);
            wr     = (op == OP_ADD) || (op == OP_LD) || (op == OP_JAL) || (op == OP_JB);
            jmp    = (op == OP_JAL) || (op == OP_JB);
            e_total += flat[pc] + 3;
            if (is_mem) begin
                e_total += 1 + mlat[pc]; e_mem += 1 + mlat[pc];
                if (op == OP_ST) e_we += 1 + mlat[pc];
            end
            if (wr) begin e_total += 1; e_rw++; end
            if (jmp)                            pc = int'(jt_mem[pc]);
            else if (op == OP_EQ && zero_mem[pc]) pc = (pc + 2) % MEM_N;
            else                                pc = (pc + 1) % MEM_N;
            guard++;
        end
        e_total += 1;
    endtask

    typedef struct {
        logic [2:0] op;
        int pc_at;
        bit zero;
        int jt;
        int ml;
        int exp_next;
        int exp_lat;
        int exp_rw;
        int exp_mem;
        int exp_we;
    } vec_t;

    vec_t vecs[12];

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Prog_end = '0;
        Ifetch_ack = 1'b0; Mem_ack = 1'b0;
        clear_prog();

        vecs[0]  = '{OP_ADD, 0,    1'b0, 0,    0, 1,    4, 1, 0, 0};
        vecs[1]  = '{OP_NOP, 3,    1'b0, 0,    0, 4,    3, 0, 0, 0};
        vecs[2]  = '{OP_EQ,  10,   1'b1, 0,    0, 12,   3, 0, 0, 0};
        vecs[3]  = '{OP_EQ,  10,   1'b0, 0,    0, 11,   3, 0, 0, 0};
        vecs[4]  = '{OP_LD,  5,    1'b0, 0,    3, 6,    8, 1, 4, 0};
        vecs[5]  = '{OP_LD,  5,    1'b0, 0,    0, 6,    5, 1, 1, 0};
        vecs[6]  = '{OP_ST,  7,    1'b0, 0,    0, 8,    4, 0, 1, 1};
        vecs[7]  = '{OP_ST,  7,    1'b0, 0,    2, 8,    6, 0, 3, 3};
        vecs[8]  = '{OP_JAL, 20,   1'b0, 300,  0, 300,  4, 1, 0, 0};
        vecs[9]  = '{OP_JB,  0,    1'b1, 1023, 0, 1023, 4, 1, 0, 0};
        vecs[10] = '{OP_ADD, 1023, 1'b0, 0,    0, 0,    4, 1, 0, 0};
        vecs[11] = '{OP_EQ,  1023, 1'b1, 0,    0, 1,    3, 0, 0, 0};

        // Reset values
        #12;
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_ifetch_req", int'(Ifetch_req), 0);
        check("rst_mem_req", int'(Mem_req), 0);
        check("rst_regwrite_en", int'(RegWrite_en), 0);
        check("rst_cycle_cnt", int'(Cycle_cnt), 0);
        check("rst_instr_addr", int'(Instr_addr), 0);
        @(negedge Clk); #1 Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        check("idle_hold_busy", int'(Busy), 0);
        check("idle_hold_req", int'(Ifetch_req), 0);

        // Empty program: one fetch cycle without a request, then done
        Prog_end = '0;
        do_start();
        check("empty_busy", int'(Busy), 1);
        check("empty_no_req", int'(Ifetch_req), 0);
        @(negedge Clk); #1;
        check("empty_done", int'(Done), 1);
        check("empty_cnt", int'(Cycle_cnt), 1);
        check("empty_fetches", fetched.size(), 0);

        // Three ADDs with immediate acks
        clear_prog();
        for (int i = 0; i < 3; i++) imem[i] = {6'b000111, OP_ADD};
        Prog_end = PC_W'(3);
        do_start();
        wait_done("add3", 100);
        check("add3_rw_n", rw_at.size(), 3);
        if (rw_at.size() == 3) begin
            check("add3_rw0", rw_at[0], 4);
            check("add3_rw1", rw_at[1], 8);
            check("add3_rw2", rw_at[2], 12);
        end
        check("add3_cnt", int'(Cycle_cnt), 13);
        repeat (3) @(negedge Clk);
        #1;
        check("add3_cnt_hold", int'(Cycle_cnt), 13);

        // Restart from DONE with a stray Start pulse while busy
        do_start();
        repeat (4) @(negedge Clk);
        #1 Start = 1'b1;
        @(negedge Clk); #1 Start = 1'b0;
        wait_done("restart", 100);
        check("restart_cnt", int'(Cycle_cnt), 13);
        check("restart_busy_cyc", busy_cyc, 13);
        check("restart_fetches", fetched.size(), 3);

        // Cycle counter saturation
        clear_prog();
        for (int i = 0; i < 20; i++) imem[i] = {6'b000111, OP_ADD};
        Prog_end = PC_W'(20);
        do_start();
        wait_done("sat", 300);
        check("sat_cnt", int'(Cycle_cnt), CNT_MAX);

        // Single-instruction vectors: latency, next PC and strobes
        for (int v = 0; v < 12; v++) begin
            int need, t0, lat, w;
            clear_prog();
            Prog_end = PC_W'(500);
            if (vecs[v].pc_at != 0) begin
                imem[0]   = {6'b101010, OP_JAL};
                jt_mem[0] = PC_W'(vecs[v].pc_at);
            end
            imem[vecs[v].pc_at]     = {6'b101010, vecs[v].op};
            zero_mem[vecs[v].pc_at] = vecs[v].zero;
            jt_mem[vecs[v].pc_at]   = PC_W'(vecs[v].jt);
            mlat[vecs[v].pc_at]     = vecs[v].ml;
            do_reset();
            do_start();
            need = (vecs[v].pc_at != 0) ? 2 : 1;
            w = 0;
            while (fetched.size() < need && w < 50) begin @(negedge Clk); #1; w++; end
            check($sformatf("vec%0d_reached", v), int'(fetched.size() >= need), 1);
            t0 = cyc;
            rw_cnt = 0; memreq_cyc = 0; memwe_cyc = 0;
            w = 0;
            do begin @(negedge Clk); #1; w++; end while (!Ifetch_req && w < 30);
            lat = cyc - t0;
            check($sformatf("vec%0d_instr_reg", v), int'(Instr_reg), int'(imem[vecs[v].pc_at]));
            check($sformatf("vec%0d_next_pc", v), int'(Instr_addr), vecs[v].exp_next);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_regwrite", v), rw_cnt, vecs[v].exp_rw);
            check($sformatf("vec%0d_mem_cyc", v), memreq_cyc, vecs[v].exp_mem);
            check($sformatf("vec%0d_we_cyc", v), memwe_cyc, vecs[v].exp_we);
        end

        // Reset in the middle of a memory access, then a late ack
        begin
            int w;
            clear_prog();
            imem[0] = {6'b101010, OP_LD};
            mlat[0] = 100;
            Prog_end = PC_W'(50);
            do_reset();
            do_start();
            w = 0;
            while (!Mem_req && w < 20) begin @(negedge Clk); #1; w++; end
            check("midmem_req_seen", int'(Mem_req), 1);
            Reset_n = 1'b0;
            #1;
            check("midmem_mem_req", int'(Mem_req), 0);
            check("midmem_busy", int'(Busy), 0);
            check("midmem_instr_reg", int'(Instr_reg), 0);
            check("midmem_cnt", int'(Cycle_cnt), 0);
            resp_en = 1'b0;
            Mem_ack = 1'b1; Ifetch_ack = 1'b1;
            @(negedge Clk); #1 Reset_n = 1'b1;
            repeat (4) @(negedge Clk);
            #1;
            check("late_ack_busy", int'(Busy), 0);
            check("late_ack_mem_req", int'(Mem_req), 0);
            check("late_ack_regwrite", int'(RegWrite_en), 0);
            check("late_ack_pc", int'(Instr_addr), 0);
            check("late_ack_cnt", int'(Cycle_cnt), 0);
            Mem_ack = 1'b0; Ifetch_ack = 1'b0;
            fcnt = 0; mcnt = 0;
            resp_en = 1'b1;
        end

        // Randomized programs against the reference model
        for (int r = 0; r < 30; r++) begin
            int pe, mism;
            clear_prog();
            pe = $urandom_range(1, 24);
            Prog_end = PC_W'(pe);
            for (int pc = 0; pc < pe; pc++) begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 6));
                imem[pc]     = {6'($urandom), op};
                zero_mem[pc] = 1'($urandom);
                if (op == OP_EQ && pc + 2 > pe) zero_mem[pc] = 1'b0;
                flat[pc]     = $urandom_range(0, 3);
                mlat[pc]     = $urandom_range(0, 3);
                jt_mem[pc]   = PC_W'(pc + 1 + $urandom_range(0, pe - pc - 1));
            end
            model_run();
            do_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(negedge Clk);
                #1;
                if (Busy) begin
                    Start = 1'b1;
                    @(negedge Clk); #1 Start = 1'b0;
                end
            end
            wait_done($sformatf("rand%0d", r), 2000);
            check($sformatf("rand%0d_fetch_n", r), fetched.size(), exp_fetch.size());
            mism = 0;
            if (fetched.size() == exp_fetch.size())
                foreach (fetched[k]) if (fetched[k] != exp_fetch[k]) mism++;
            check($sformatf("rand%0d_fetch_seq_mism", r), mism, 0);
            check($sformatf("rand%0d_busy_cyc", r), busy_cyc, e_total);
            check($sformatf("rand%0d_cnt", r), int'(Cycle_cnt), (e_total > CNT_MAX) ? CNT_MAX : e_total);
            check($sformatf("rand%0d_regwrite", r), rw_cnt, e_rw);
            check($sformatf("rand%0d_mem_cyc", r), memreq_cyc, e_mem);
            check($sformatf("rand%0d_we_cyc", r), memwe_cyc, e_we);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
